cordic_vector: RTL and testbench

- Iterative CORDIC in vectoring mode: the inverse of the existing rotation-mode sine/cosine unit. Given a Cartesian vector (x, y) it returns the angle atan2(y, x) and the gain-corrected magnitude sqrt(x²+y²).
- Used by game logic to turn ball velocity components back into a heading angle and speed, for example after a paddle bounce.
- One iteration per clock, with a start/busy/done handshake.

---
 rtl/cordic_vector.sv | 143 ++++++++++++++
 tb/tb_cordic_vector.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a Q2.30 vector (x, y) into its
// angle atan2(y, x) in Q3.29 radians and its gain-corrected Q2.30 magnitude.
module cordic_vector #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] angle_out,
  output logic [31:0] mag_out
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;

  localparam logic [31:0] HALF_PI     = 32'h3243F6A9;
  localparam logic [31:0] NEG_HALF_PI = 32'hCDBC0957;
  localparam logic [31:0] K_GAIN      = 32'h26DD3B6A;

  // round(atan(2^-i) * 2^29); a constant ROM, so it carries no reset.
  localparam logic [31:0] BETA [32] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  state_t             state_q, state_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic        [31:0] z_q, z_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic        [31:0] angle_q, angle_d, mag_q, mag_d;

  logic signed [33:0] x_ext, y_ext, x_sh, y_sh;
  logic signed [65:0] x_wide, k_wide, prod;
  logic               unused_prod_lo;

  assign x_ext  = {{2{x_in[31]}}, x_in};
  assign y_ext  = {{2{y_in[31]}}, y_in};
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign x_wide = {{32{x_q[33]}}, x_q};
  assign k_wide = {34'd0, K_GAIN};
  assign prod   = x_wide * k_wide;
  assign unused_prod_lo = ^prod[29:0];

  // NOTE: every next-state signal gets its hold value first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = S_ITER;
          // Fold the left half-plane into the right so the iterations converge.
          if (!x_in[31]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_in[31]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = HALF_PI;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = NEG_HALF_PI;
          end
        end
      end
      S_ITER: begin
        if (!y_q[33]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + BETA[cnt_q];
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - BETA[cnt_q];
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        // A zero vector never rotates, so z would collect every beta term.
        angle_d = zero_q ? '0 : z_q;
        if (prod[65])             mag_d = '0;
        else if (|prod[64:61])    mag_d = 32'h7FFFFFFF;
        else                      mag_d = prod[61:30];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the previous-cycle values, matching the simultaneous CORDIC update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: quadrant vectors, zero and negative-x
// boundaries, latency/handshake, mid-run reset and held-start re-trigger.
module tb_cordic_vector;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] x_in, y_in;
  logic        busy, done;
  logic [31:0] angle_out, mag_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_vector #(.ITERS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .angle_out(angle_out),
    .mag_out  (mag_out)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input int tol);
    longint diff;
    diff = longint'($signed(obs - exp));
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Called just after a negedge; pulses start and watches 60 cycles.
  task automatic run(input logic [31:0] xv, input logic [31:0] yv,
                     output int lat, output int busy_cnt, output int done_cnt);
    x_in = xv;
    y_in = yv;
    start = 1'b1;
    lat = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic vec_test(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] ea, input int ta,
                          input logic [31:0] em, input int tm);
    int lat, bc, dc;
    run(xv, yv, lat, bc, dc);
    check({tag, "_latency"}, lat, 34, 0);
    check({tag, "_done_cnt"}, dc, 1, 0);
    check({tag, "_busy_cnt"}, bc, 34, 0);
    check({tag, "_angle"}, angle_out, ea, ta);
    check({tag, "_mag"}, mag_out, em, tm);
  endtask

  task automatic reset_abort_test();
    int dc;
    dc = 0;
    x_in = 32'h20000000;
    y_in = 32'h20000000;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) reset = 1'b0;
      if (c == 11) begin
        check("arst_busy", busy, 0, 0);
        check("arst_done", done, 0, 0);
        check("arst_angle", angle_out, 0, 0);
        check("arst_mag", mag_out, 0, 0);
      end
      if (c == 12) reset = 1'b1;
      if (c == 13) check("arst_idle", busy, 0, 0);
      if (done) dc++;
    end
    check("arst_no_done", dc, 0, 0);
  endtask

  task automatic held_start_test();
    logic [31:0] snap_a, snap_m;
    int n_chg, d1, d2, nd;
    n_chg = 0;
    d1 = -1;
    d2 = -1;
    nd = 0;
    snap_a = '0;
    snap_m = '0;
    x_in = 32'h40000000;
    y_in = 32'h00000000;
    start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 34) begin
        check("hold_run1_angle", angle_out, 32'h00000000, 8);
        check("hold_run1_mag", mag_out, 32'h40000000, 16);
        snap_a = angle_out;
        snap_m = mag_out;
      end
      if (c == 35) begin
        check("hold_idle_gap", busy, 0, 0);
        x_in = 32'h00000000;
        y_in = 32'h20000000;
      end
      if (c == 36) check("hold_restart", busy, 1, 0);
      if (c >= 35 && c <= 68 && (angle_out != snap_a || mag_out != snap_m)) n_chg++;
      if (c == 69) start = 1'b0;
    end
    check("hold_first_done", d1, 34, 0);
    check("hold_second_done", d2, 69, 0);
    check("hold_done_cnt", nd, 2, 0);
    check("hold_outputs_held", n_chg, 0, 0);
    check("hold_run2_angle", angle_out, 32'h3243F6A9, 8);
    check("hold_run2_mag", mag_out, 32'h20000000, 16);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_angle", angle_out, 0, 0);
    check("rst_mag", mag_out, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    vec_test("diag",  32'h20000000, 32'h20000000, 32'h1921FB54, 8, 32'h2D413CCD, 16);
    vec_test("pos_y", 32'h00000000, 32'h20000000, 32'h3243F6A9, 8, 32'h20000000, 16);
    vec_test("neg_y", 32'h00000000, 32'hE0000000, 32'hCDBC0957, 8, 32'h20000000, 16);
    vec_test("neg_x", 32'hE0000000, 32'h00000000, 32'h6487ED51, 8, 32'h20000000, 16);

    reset_abort_test();
    vec_test("fresh", 32'h40000000, 32'h00000000, 32'h00000000, 8, 32'h40000000, 16);
    vec_test("zero",  32'h00000000, 32'h00000000, 32'h00000000, 4, 32'h00000000, 4);

    held_start_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
